conv2_stream: RTL and testbench
===============================

# conv2_stream

Streaming, parametrised successor to the `conv2` whole-matrix convolver. It takes a SIZE×SIZE signed image as a raster pixel stream with valid/ready handshakes and holds KER−1 rows in line buffers. It convolves the image with a run-time-loadable KER×KER kernel at a configurable stride and emits a saturated, rescaled output stream. It sits between the image source (memory reader or previous layer) and the next CNN stage. It pulses `done` after the last output pixel of each frame.

## Interface
- `SIZE`, 320, image rows = columns
- `KER`, 3, kernel rows = columns (≥2, ≤ SIZE)
- `WIDTH_BIT`, 16, signed pixel, kernel and output width
- `STRIDE`, 1, window step in both dimensions (≥1)
- `SHIFT`, 0, arithmetic right shift applied to the accumulator before saturation
- `clock` in 1: single clock, all logic on its rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: begins a frame; honoured only in IDLE
- `ker_we` in 1: kernel coefficient write strobe; honoured only in IDLE
- `ker_addr` in clog2(KER*KER): row-major coefficient index (row*KER+col)
- `ker_data` in WIDTH_BIT: signed coefficient
- `in_valid` in 1, `in_ready` out 1, `in_pixel` in WIDTH_BIT: raster-order input stream
- `out_valid` out 1, `out_ready` in 1, `out_pixel` out WIDTH_BIT: raster-order output stream
- `done` out 1: one-cycle pulse at frame end
- `busy` out 1: high in RUN and DONE

## Operation
- States: IDLE → RUN on `start`; RUN → DONE on the handshake of the last output; DONE → IDLE unconditionally after 1 cycle.
- IDLE: `ker_we` writes `ker_data` to `kernel[ker_addr]`. Addresses ≥ KER*KER are ignored. Kernel writes in RUN/DONE are ignored. The kernel persists across frames.
- RUN: an input beat transfers when `in_valid && in_ready`. Each beat advances column counter `c` (0..SIZE−1) and row counter `r` (0..SIZE−1), wrapping `c` to 0 and incrementing `r`.
- Line buffer: KER−1 rows of SIZE entries, shift-on-accept. The window register holds the last KER columns of each of the KER rows.
- An output is produced for an accepted pixel when r ≥ KER−1, c ≥ KER−1, (r−KER+1) mod STRIDE = 0 and (c−KER+1) mod STRIDE = 0.
- Frame output: OUT×OUT pixels in raster order, with OUT = (SIZE−KER)/STRIDE + 1 (integer division). Trailing pixels that complete no window are accepted and dropped.
- Arithmetic: the KER*KER signed WIDTH_BIT×WIDTH_BIT products are summed at full width ACC_W = 2·WIDTH_BIT + clog2(KER*KER). The sum is arithmetically shifted right by SHIFT (floor), then saturated to [−2^(WIDTH_BIT−1), 2^(WIDTH_BIT−1)−1].
- Window orientation: `kernel[i][j]` multiplies the pixel at (r−KER+1+i, c−KER+1+j). This is correlation form, matching `conv2`.
- `in_ready` = (state == RUN) && (!out_valid || out_ready) && input not yet complete (fewer than SIZE·SIZE beats accepted).
- `start` while busy: ignored. `in_valid` outside RUN: not accepted.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_pixel`=0, `done`=0, `busy`=0, state IDLE, counters 0, line buffers and kernel 0.
- Latency: `out_valid` rises the cycle after the accepting edge of the window-completing pixel (1-cycle registered MAC).
- `out_pixel` and `out_valid` are held stable while `out_valid && !out_ready`. No new input is accepted during that stall.
- Throughput: 1 pixel/cycle with `out_ready` held high.
- The last output handshake moves the state to DONE. `done`=1 during that DONE cycle; IDLE follows on the next cycle.
- If the last output handshake and a `start` arrive in the same cycle, `start` is ignored.
- `reset` asserted mid-frame: all outputs return to their reset values immediately and asynchronously. The partial frame is discarded and the kernel is cleared.

## Structure
- Package `conv_pkg`:
  - state enum `conv_state_t` {IDLE, RUN, DONE}
  - function `out_size(SIZE,KER,STRIDE)`
  - function `acc_width(WIDTH_BIT,KER)`
  - function `sat_shift(acc, SHIFT, WIDTH_BIT)`
- Sub-module `line_buffer` (parameters DEPTH=SIZE, ROWS=KER−1, WIDTH_BIT): shift-on-enable row storage exposing the KER column taps.
- The top level holds the FSM, counters, window registers, MAC and output register.

## Test plan
- Sum kernel: SIZE=5, KER=3, STRIDE=1; all-ones image, all-ones kernel → 9 outputs of 9, one `done` pulse, `busy` low afterwards.
- Identity kernel: kernel[1][1]=1, others 0; ramp image p(r,c)=5r+c → outputs 6,7,8,11,12,13,16,17,18.
- Saturation: WIDTH_BIT=16, image 0x7FFF, all-ones kernel → every output 0x7FFF. Image 0x8000 → every output 0x8000. Same image with SHIFT=4 and kernel 1 → no clipping; value = floor(sum/16).
- Stride: SIZE=5, KER=3, STRIDE=2, ramp image, identity kernel → 4 outputs 6,8,16,18. Trailing pixels are accepted without extra outputs.
- Backpressure: `out_ready` low for 10 cycles mid-frame → `in_ready` low, `out_pixel` stable. Resuming gives an identical output sequence with no loss or duplication.
- Reset mid-frame after 12 input beats → outputs at reset values. The kernel must be reloaded; a new `start` produces a correct full frame. Kernel writes in RUN are verified ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the streaming convolver.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} conv_state_t;

  // Working width for the shift/saturate helper. Callers sign-extend their
  // accumulator into it, so acc_width() must stay below this value.
  localparam int SAT_W = 64;

  // Outputs per dimension. Trailing columns/rows that cannot complete a
  // window are dropped by the integer division.
  function automatic int out_size(input int size, input int ker, input int stride);
    return (size - ker) / stride + 1;
  endfunction

  // Full-precision accumulator width: one product plus growth for KER*KER terms.
  function automatic int acc_width(input int width_bit, input int ker);
    return 2 * width_bit + $clog2(ker * ker);
  endfunction

  // Arithmetic (floor) right shift, then clamp to the signed width_bit range.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                        input int shift,
                                                        input int width_bit);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (width_bit - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width_bit - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Holds ROWS previous image rows as chained shift registers, one shift per accepted pixel.
// Latency: a tap shows the pixel pushed DEPTH*(k+1) enables earlier.
// Backpressure: none internally; the caller gates en with its own handshake.
module line_buffer #(
  parameter int DEPTH     = 320,
  parameter int ROWS      = 2,
  parameter int WIDTH_BIT = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           en,
  input  logic [WIDTH_BIT-1:0]           din,
  output logic [ROWS-1:0][WIDTH_BIT-1:0] taps
);

  logic [WIDTH_BIT-1:0] mem [ROWS][DEPTH];

  // Shift every row by one entry; each row is fed by the tail of the row above.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int d = 0; d < DEPTH; d++)
          mem[r][d] <= '0;
    end else if (en) begin
      mem[0][0] <= din;
      for (int r = 1; r < ROWS; r++)
        mem[r][0] <= mem[r-1][DEPTH-1];
      for (int r = 0; r < ROWS; r++)
        for (int d = 1; d < DEPTH; d++)
          mem[r][d] <= mem[r][d-1];
    end
  end

  // Oldest entry of each row is the same column one (or more) rows up.
  always_comb begin
    for (int r = 0; r < ROWS; r++)
      taps[r] = mem[r][DEPTH-1];
  end

endmodule

// File: rtl/conv2_stream.sv
// Streaming KERxKER strided correlation of a SIZExSIZE raster image, shifted and saturated.
// Latency: out_valid rises one cycle after the window-completing pixel is accepted.
// Backpressure: a held output (out_valid && !out_ready) stalls the input; up to 1 pixel/cycle.
module conv2_stream
  import conv_pkg::*;
#(
  parameter int SIZE      = 320,
  parameter int KER       = 3,
  parameter int WIDTH_BIT = 16,
  parameter int STRIDE    = 1,
  parameter int SHIFT     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         ker_we,
  input  logic [$clog2(KER*KER)-1:0]   ker_addr,
  input  logic [WIDTH_BIT-1:0]         ker_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH_BIT-1:0]         in_pixel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH_BIT-1:0]         out_pixel,
  output logic                         done,
  output logic                         busy
);

  localparam int KK    = KER * KER;
  localparam int ACC_W = acc_width(WIDTH_BIT, KER);
  localparam int OUT   = out_size(SIZE, KER, STRIDE);
  localparam int LAST  = (OUT - 1) * STRIDE + KER - 1;  // row/col of the final window
  localparam int CW    = $clog2(SIZE);
  localparam int SW    = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  conv_state_t state_q, state_d;

  logic [CW-1:0] c, r;
  logic [SW-1:0] cp, rp;        // stride phase of c and r once past KER-1
  logic          in_complete;
  logic          out_last;
  logic          accept, emit, is_last;

  logic signed [WIDTH_BIT-1:0] kernel [KK];
  logic signed [WIDTH_BIT-1:0] win    [KER][KER];
  logic signed [WIDTH_BIT-1:0] nwin   [KER][KER];
  logic signed [WIDTH_BIT-1:0] col    [KER];
  logic [KER-2:0][WIDTH_BIT-1:0] taps;
  logic signed [ACC_W-1:0]     acc;
  logic signed [SAT_W-1:0]     sat_val;

  assign in_ready = (state_q == RUN) && (!out_valid || out_ready) && !in_complete;
  assign accept   = in_valid && in_ready;
  assign emit     = (r >= CW'(KER - 1)) && (c >= CW'(KER - 1)) && (rp == '0) && (cp == '0);
  assign is_last  = (r == CW'(LAST)) && (c == CW'(LAST));
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);

  line_buffer #(.DEPTH(SIZE), .ROWS(KER - 1), .WIDTH_BIT(WIDTH_BIT)) u_lb (
    .clock (clock),
    .reset (reset),
    .en    (accept),
    .din   (in_pixel),
    .taps  (taps)
  );

  // Assemble the incoming column (newest row at the bottom) and the shifted window.
  always_comb begin
    col[KER-1] = $signed(in_pixel);
    for (int k = 0; k < KER - 1; k++)
      col[KER-2-k] = $signed(taps[k]);
    for (int i = 0; i < KER; i++) begin
      for (int j = 0; j < KER - 1; j++)
        nwin[i][j] = win[i][j+1];
      nwin[i][KER-1] = col[i];
    end
  end

  // Full-precision correlation sum over the window that includes the current pixel.
  always_comb begin
    acc = '0;
    for (int i = 0; i < KER; i++)
      for (int j = 0; j < KER; j++)
        acc = acc + ACC_W'(kernel[i*KER+j]) * ACC_W'(nwin[i][j]);
  end

  assign sat_val = sat_shift(SAT_W'(acc), SHIFT, WIDTH_BIT);

  // Kernel coefficients are only writable while idle; out-of-range addresses drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < KK; k++)
        kernel[k] <= '0;
    end else if (state_q == IDLE && ker_we && int'(ker_addr) < KK) begin
      kernel[ker_addr] <= $signed(ker_data);
    end
  end

  // Raster counters, stride phases, window shift and registered output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c <= '0; r <= '0; cp <= '0; rp <= '0;
      in_complete <= 1'b0;
      out_valid   <= 1'b0;
      out_pixel   <= '0;
      out_last    <= 1'b0;
      for (int i = 0; i < KER; i++)
        for (int j = 0; j < KER; j++)
          win[i][j] <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        c <= '0; r <= '0; cp <= '0; rp <= '0;
        in_complete <= 1'b0;
      end else if (accept) begin
        if (c == CW'(SIZE - 1)) begin
          c  <= '0;
          cp <= '0;
          if (r == CW'(SIZE - 1)) in_complete <= 1'b1;
          else                    r <= r + 1'b1;
          if (r >= CW'(KER - 1)) rp <= (rp == SW'(STRIDE - 1)) ? '0 : rp + 1'b1;
          else                   rp <= '0;
        end else begin
          c <= c + 1'b1;
          if (c >= CW'(KER - 1)) cp <= (cp == SW'(STRIDE - 1)) ? '0 : cp + 1'b1;
          else                   cp <= '0;
        end
      end
      if (accept) begin
        for (int i = 0; i < KER; i++)
          for (int j = 0; j < KER; j++)
            win[i][j] <= nwin[i][j];
      end
      if (accept && emit) begin
        out_valid <= 1'b1;
        out_pixel <= WIDTH_BIT'(sat_val);
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: start only from IDLE; the last output handshake ends the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (out_valid && out_ready && out_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv2_stream.sv
module tb_conv2_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_bc = 1'b0;
  logic        ker_we = 1'b0;
  logic [3:0]  ker_addr = '0;
  logic [15:0] ker_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_pixel = '0;
  logic        out_ready_a = 1'b1, rdy_bc = 1'b1;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [15:0] out_pixel_a, out_pixel_b, out_pixel_c;
  logic        done_a, done_b, done_c;
  logic        busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;
  int qa[$], qb[$], qc[$];
  int e[9];

  always #5 clock = ~clock;

  conv2_stream #(.SIZE(5), .KER(3), .WIDTH_BIT(16), .STRIDE(1), .SHIFT(0)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .ker_we(ker_we), .ker_addr(ker_addr),
    .ker_data(ker_data), .in_valid(in_valid), .in_ready(in_ready_a), .in_pixel(in_pixel),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_pixel(out_pixel_a),
    .done(done_a), .busy(busy_a));

  conv2_stream #(.SIZE(5), .KER(3), .WIDTH_BIT(16), .STRIDE(2), .SHIFT(0)) dut_b (
    .clock(clock), .reset(reset), .start(start_bc), .ker_we(ker_we), .ker_addr(ker_addr),
    .ker_data(ker_data), .in_valid(in_valid), .in_ready(in_ready_b), .in_pixel(in_pixel),
    .out_valid(out_valid_b), .out_ready(rdy_bc), .out_pixel(out_pixel_b),
    .done(done_b), .busy(busy_b));

  conv2_stream #(.SIZE(5), .KER(3), .WIDTH_BIT(16), .STRIDE(1), .SHIFT(4)) dut_c (
    .clock(clock), .reset(reset), .start(start_bc), .ker_we(ker_we), .ker_addr(ker_addr),
    .ker_data(ker_data), .in_valid(in_valid), .in_ready(in_ready_c), .in_pixel(in_pixel),
    .out_valid(out_valid_c), .out_ready(rdy_bc), .out_pixel(out_pixel_c),
    .done(done_c), .busy(busy_c));

  // Record every output handshake and every done pulse of the stride-1 instance.
  always @(negedge clock) begin
    if (out_valid_a && out_ready_a) qa.push_back(int'($signed(out_pixel_a)));
    if (out_valid_b && rdy_bc)      qb.push_back(int'($signed(out_pixel_b)));
    if (out_valid_c && rdy_bc)      qc.push_back(int'($signed(out_pixel_c)));
    if (done_a) done_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input int which, input int n, input int exp [9]);
    int q[$];
    case (which)
      0:       q = qa;
      1:       q = qb;
      default: q = qc;
    endcase
    check({tag, "_len"}, q.size(), n);
    for (int i = 0; i < n && i < q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), q[i], exp[i]);
  endtask

  function automatic logic [15:0] pix(input int mode, input int r, input int c);
    case (mode)
      0:       return 16'd1;
      1:       return 16'(5 * r + c);
      2:       return 16'h7FFF;
      default: return 16'h8000;
    endcase
  endfunction

  task automatic write_ker(input int addr, input int data);
    ker_we = 1'b1; ker_addr = 4'(addr); ker_data = 16'(data);
    @(posedge clock); #1;
    ker_we = 1'b0;
  endtask

  task automatic begin_frame(input logic a, input logic bc);
    qa.delete(); qb.delete(); qc.delete();
    d0 = done_cnt;
    start_a = a; start_bc = bc;
    @(posedge clock); #1;
    start_a = 1'b0; start_bc = 1'b0;
  endtask

  // Feed nbeats raster pixels; optional output stall, kernel write or start poke at a beat.
  task automatic feed(input int mode, input int nbeats, input int stall_at,
                      input int hold_val, input int ker_poke_at, input int start_poke_at);
    for (int idx = 0; idx < nbeats; idx++) begin
      int n;
      in_valid = 1'b1;
      in_pixel = pix(mode, idx / 5, idx % 5);
      if (idx == ker_poke_at) begin ker_we = 1'b1; ker_addr = 4'd4; ker_data = 16'd5; end
      if (idx == start_poke_at) begin start_a = 1'b1; start_bc = 1'b1; end
      n = 0;
      @(negedge clock);
      while (!in_ready_a && n < 50) begin n++; @(negedge clock); end
      check("in_ready_wait", int'(in_ready_a), 1);
      @(posedge clock); #1;
      ker_we = 1'b0; start_a = 1'b0; start_bc = 1'b0;
      if (idx == stall_at) begin
        out_ready_a = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clock);
          check("stall_in_ready", int'(in_ready_a), 0);
          check("stall_out_valid", int'(out_valid_a), 1);
          check("stall_out_pixel", int'($signed(out_pixel_a)), hold_val);
        end
        out_ready_a = 1'b1;
        @(posedge clock); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int n = 0;
    while ((busy_a || busy_b || busy_c) && n < 40) begin @(posedge clock); #1; n++; end
    check({tag, "_busy_low"}, int'(busy_a | busy_b | busy_c), 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", int'(in_ready_a), 0);
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_out_pixel", int'(out_pixel_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_busy", int'(busy_a | busy_b | busy_c), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // Sum kernel on an all-ones image; start coincides with the last handshake
    for (int k = 0; k < 9; k++) write_ker(k, 1);
    write_ker(12, 7);
    begin_frame(1'b1, 1'b1);
    feed(0, 25, -1, 0, -1, -1);
    start_a = 1'b1; start_bc = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0; start_bc = 1'b0;
    check("f1_busy_in_done", int'(busy_a), 1);
    check("f1_done_high", int'(done_a), 1);
    @(posedge clock); #1;
    check("f1_start_ignored", int'(busy_a | busy_b | busy_c), 0);
    check("f1_done_pulses", done_cnt - d0, 1);
    e = '{9, 9, 9, 9, 9, 9, 9, 9, 9};  check_q("f1_a", 0, 9, e);
    e = '{9, 9, 9, 9, 0, 0, 0, 0, 0};  check_q("f1_b", 1, 4, e);
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0};  check_q("f1_c", 2, 9, e);

    // Positive saturation, with a start pulse mid-frame that must be ignored
    begin_frame(1'b1, 1'b1);
    feed(2, 25, -1, 0, -1, 5);
    finish_frame("f2");
    e = '{default: 32767};             check_q("f2_a", 0, 9, e);
    check_q("f2_b", 1, 4, e);
    e = '{default: 18431};             check_q("f2_c", 2, 9, e);

    // Negative saturation
    begin_frame(1'b1, 1'b1);
    feed(3, 25, -1, 0, -1, -1);
    finish_frame("f3");
    e = '{default: -32768};            check_q("f3_a", 0, 9, e);
    check_q("f3_b", 1, 4, e);
    e = '{default: -18432};            check_q("f3_c", 2, 9, e);

    // Identity kernel on a ramp; a kernel write during RUN must not land
    for (int k = 0; k < 9; k++) write_ker(k, (k == 4) ? 1 : 0);
    begin_frame(1'b1, 1'b1);
    feed(1, 25, -1, 0, 3, -1);
    finish_frame("f4");
    e = '{6, 7, 8, 11, 12, 13, 16, 17, 18}; check_q("f4_a", 0, 9, e);
    e = '{6, 8, 16, 18, 0, 0, 0, 0, 0};     check_q("f4_b", 1, 4, e);
    e = '{0, 0, 0, 0, 0, 0, 1, 1, 1};       check_q("f4_c", 2, 9, e);

    // Output stall for 10 cycles while the second output (7) is held
    begin_frame(1'b1, 1'b0);
    feed(1, 25, 13, 7, -1, -1);
    finish_frame("f5");
    e = '{6, 7, 8, 11, 12, 13, 16, 17, 18}; check_q("f5_a", 0, 9, e);

    // Asynchronous reset after 12 beats
    begin_frame(1'b1, 1'b1);
    feed(1, 12, -1, 0, -1, -1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", int'(in_ready_a), 0);
    check("mid_rst_out_valid", int'(out_valid_a), 0);
    check("mid_rst_out_pixel", int'(out_pixel_a), 0);
    check("mid_rst_done", int'(done_a), 0);
    check("mid_rst_busy", int'(busy_a | busy_b | busy_c), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // Kernel was cleared: a frame without reload yields zeros
    begin_frame(1'b1, 1'b1);
    feed(1, 25, -1, 0, -1, -1);
    finish_frame("f6");
    e = '{default: 0};
    check_q("f6_a", 0, 9, e);
    check_q("f6_b", 1, 4, e);

    // Reloaded kernel gives a correct full frame
    for (int k = 0; k < 9; k++) write_ker(k, (k == 4) ? 1 : 0);
    begin_frame(1'b1, 1'b1);
    feed(1, 25, -1, 0, -1, -1);
    finish_frame("f7");
    e = '{6, 7, 8, 11, 12, 13, 16, 17, 18}; check_q("f7_a", 0, 9, e);
    e = '{6, 8, 16, 18, 0, 0, 0, 0, 0};     check_q("f7_b", 1, 4, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
